ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 16-bit pipeline; sits between ID and MEM.
//  Computes the ALU result, drives the MEM-stage inputs (mem_ir, reg_C, dw, smdr1)
//  and owns the architectural flags zf/nf/cf.
//  All state advances only while state == `exec; opcodes are ir[15:11], macros from define.v.
// PARAMETERS
//  WIDTH    16  datapath width; only 16 is supported
//  MUL_CYC  16  iterations of the optional shift-add multiplier
// PORTS
//  clock    in   1   system clock, posedge
//  reset    in   1   asynchronous, active-low
//  state    in   1   CPU run state; registers update only when == `exec
//  ex_ir    in   16  instruction in EX
//  reg_A    in   16  operand A from ID
//  reg_B    in   16  operand B from ID (immediates already extended/placed by ID)
//  smdr     in   16  store data from ID
//  mem_ir   out  16  instruction to MEM (registered)
//  reg_C    out  16  ALU result / memory address (registered)
//  dw       out  1   data-memory write enable for MEM (registered)
//  smdr1    out  16  store data to MEM (registered)
//  zf,nf,cf out  1   zero / negative / carry-borrow flags (registered)
//  stall    out  1   combinational; 1 = IF/ID must hold ex_ir (0 when EX_MUL_EN off)
// BEHAVIOUR
//  Reset (async, reset==0): mem_ir, reg_C, smdr1 = 16'h0000; dw, zf, nf, cf = 0; mul busy=0, cnt=0.
//  state != `exec: every register holds; the multiplier counter freezes.
//  Latency: 1 cycle; ex_ir sampled at edge N appears on mem_ir/reg_C after edge N.
//  Each exec edge: mem_ir<=ex_ir; smdr1<=smdr; dw<=(op==`STORE).
//  reg_C by op (17-bit internal sum for carry):
//   ADD,ADDI,LOAD,STORE: A+B | ADDC: A+B+cf | SUB,SUBI,CMP: A-B | SUBC: A-B-cf
//   AND/OR/XOR: bitwise | SLL,SLA: A<<B[3:0] | SRL: logical A>>B[3:0] | SRA: arith A>>>B[3:0]
//   LDIH: B | all other ops (NOP, HALT, JUMP, branches, unknown): 16'h0000.
//  Flags update only for ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP, AND, OR, XOR, shifts; else hold.
//   zf = (result==0); nf = result[15];
//   cf = carry-out (add), borrow (sub/cmp, i.e. A<B unsigned incl. carry-in); 0 for logic/shift.
//  ADDC/SUBC use cf as registered before the edge (old value).
//  CMP writes reg_C too; downstream ignores it.
// CONFIGURATION
//  EX_MUL_EN defined: opcode `MUL is an iterative unsigned 16x16 shift-add, MUL_CYC iterations.
//   Timing:
//    - stall = (op==`MUL) && !(busy && cnt==MUL_CYC-1).
//    - First exec edge with MUL: busy<=1, cnt<=0, mem_ir<=16'h0000 (NOP bubble), dw<=0.
//    - Next MUL_CYC exec edges iterate; during busy, mem_ir is the bubble and dw=0.
//    - At the edge with cnt==MUL_CYC-1: reg_C<=product[15:0], mem_ir<=ex_ir, busy<=0.
//   Flags: zf/nf from product[15:0]; cf = |product[31:16].
//   Total occupancy: MUL_CYC+1 exec cycles; stall drops in the final one so ID advances on retire.
//   Reset mid-MUL aborts: busy=0, cnt=0, all outputs to reset values.
//  EX_MUL_EN undefined: `MUL handled as an unknown op (reg_C=0, flags hold); stall tied 0;
//   no multiplier logic synthesised.
// TESTING
//  1 ADD A=16'h7FFF B=16'h0001 -> reg_C=16'h8000, nf=1, zf=0, cf=0, mem_ir=ex_ir after 1 edge
//  2 SUB A=5 B=5 -> reg_C=0, zf=1, cf=0; then SUB A=3 B=5 -> reg_C=16'hFFFE, nf=1, cf=1;
//    then ADDC A=1 B=1 -> reg_C=3
//  3 STORE A=16'h0010 B=16'h0004 smdr=16'hBEEF -> reg_C=16'h0014, dw=1, smdr1=16'hBEEF;
//    flags unchanged; next NOP -> dw=0
//  4 SRA A=16'h8000 B=3 -> reg_C=16'hF000, cf=0; SRL same operands -> reg_C=16'h1000
//  5 state!=`exec for 4 cycles with ADD on ex_ir -> mem_ir/reg_C/flags hold;
//    reset pulse mid-stream -> all outputs 0 asynchronously
//  6 (EX_MUL_EN) MUL A=300 B=300 -> stall high 16 exec cycles, mem_ir=0 meanwhile,
//    then reg_C=16'h5F90, cf=1, zf=0; reset at iteration 8 -> busy cleared, reg_C=0

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the 16-bit pipeline: ALU, MEM-stage handoff registers and the zf/nf/cf flags.
// Latency 1 exec cycle (MUL: MUL_CYC+1 exec cycles when EX_MUL_EN is defined), nothing moves unless state==`EXEC.
// Backpressure: stall asks IF/ID to hold ex_ir while the iterative multiplier (EX_MUL_EN) is busy.

`ifndef EX_STAGE_DEFINES
`define EX_STAGE_DEFINES
`define EXEC  1'b1
`define IDLE  1'b0
`define NOP   5'b00000
`define HALT  5'b00001
`define LOAD  5'b00010
`define STORE 5'b00011
`define SLL   5'b00100
`define SRL   5'b00101
`define SLA   5'b00110
`define SRA   5'b00111
`define ADD   5'b01000
`define ADDI  5'b01001
`define SUB   5'b01010
`define SUBI  5'b01011
`define CMP   5'b01100
`define AND   5'b01101
`define OR    5'b01110
`define XOR   5'b01111
`define LDIH  5'b10000
`define ADDC  5'b10001
`define SUBC  5'b10010
`define MUL   5'b10011
`define JUMP  5'b11000
`endif

module ex_stage #(
    parameter int WIDTH = 16
`ifdef EX_MUL_EN
    , parameter int MUL_CYC = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             state,
    input  logic [WIDTH-1:0] ex_ir,
    input  logic [WIDTH-1:0] reg_A,
    input  logic [WIDTH-1:0] reg_B,
    input  logic [WIDTH-1:0] smdr,
    output logic [WIDTH-1:0] mem_ir,
    output logic [WIDTH-1:0] reg_C,
    output logic             dw,
    output logic [WIDTH-1:0] smdr1,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             stall
);

    logic [4:0]       w_op;
    logic             w_exec;
    logic [3:0]       w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_flag_upd;
    logic             w_cf_new;

    logic [WIDTH-1:0] r_mem_ir, r_reg_C, r_smdr1;
    logic             r_dw, r_zf, r_nf, r_cf;

    assign w_op   = ex_ir[WIDTH-1 -: 5];
    assign w_exec = (state == `EXEC);
    assign w_sh   = reg_B[3:0];

    // Single-cycle ALU: result, whether the op touches flags, and the new carry/borrow.
    always_comb begin
        w_sum      = '0;
        w_res      = '0;
        w_flag_upd = 1'b0;
        w_cf_new   = 1'b0;
        case (w_op)
            `ADD, `ADDI: begin
                w_sum = {1'b0, reg_A} + {1'b0, reg_B};
                w_res = w_sum[WIDTH-1:0]; w_flag_upd = 1'b1; w_cf_new = w_sum[WIDTH];
            end
            `LOAD, `STORE: begin
                w_sum = {1'b0, reg_A} + {1'b0, reg_B};
                w_res = w_sum[WIDTH-1:0];
            end
            `ADDC: begin
                w_sum = {1'b0, reg_A} + {1'b0, reg_B} + {{WIDTH{1'b0}}, r_cf};
                w_res = w_sum[WIDTH-1:0]; w_flag_upd = 1'b1; w_cf_new = w_sum[WIDTH];
            end
            // Zero-extended 17-bit subtraction: bit 16 set exactly when the result went negative.
            `SUB, `SUBI, `CMP: begin
                w_sum = {1'b0, reg_A} - {1'b0, reg_B};
                w_res = w_sum[WIDTH-1:0]; w_flag_upd = 1'b1; w_cf_new = w_sum[WIDTH];
            end
            `SUBC: begin
                w_sum = {1'b0, reg_A} - {1'b0, reg_B} - {{WIDTH{1'b0}}, r_cf};
                w_res = w_sum[WIDTH-1:0]; w_flag_upd = 1'b1; w_cf_new = w_sum[WIDTH];
            end
            `AND: begin w_res = reg_A & reg_B; w_flag_upd = 1'b1; end
            `OR:  begin w_res = reg_A | reg_B; w_flag_upd = 1'b1; end
            `XOR: begin w_res = reg_A ^ reg_B; w_flag_upd = 1'b1; end
            `SLL, `SLA: begin w_res = reg_A << w_sh; w_flag_upd = 1'b1; end
            `SRL: begin w_res = reg_A >> w_sh; w_flag_upd = 1'b1; end
            `SRA: begin w_res = WIDTH'($signed(reg_A) >>> w_sh); w_flag_upd = 1'b1; end
            `LDIH: w_res = reg_B;
            default: w_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

    logic                 r_busy;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic                 w_mul_last;
    logic                 w_mul_path;

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last  = r_busy && (r_cnt == CW'(MUL_CYC - 1));
    assign w_mul_path  = r_busy || (w_op == `MUL);
    // ID is released in the retiring cycle so the next instruction arrives right behind the product.
    assign stall       = (w_op == `MUL) && !w_mul_last;

    // Shift-add multiplier: operands latched on the first MUL edge, one multiplier bit per exec edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (w_exec) begin
            if (!r_busy && (w_op == `MUL)) begin
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, reg_A};
                r_mplier <= reg_B;
                r_prod   <= '0;
            end else if (r_busy) begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                if (w_mul_last) begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + CW'(1);
                end
            end
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Pipeline register toward MEM plus the architectural flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_ir <= '0;
            r_reg_C  <= '0;
            r_smdr1  <= '0;
            r_dw     <= 1'b0;
            r_zf     <= 1'b0;
            r_nf     <= 1'b0;
            r_cf     <= 1'b0;
        end else if (w_exec) begin
            r_smdr1 <= smdr;
`ifdef EX_MUL_EN
            if (w_mul_path) begin
                // While multiplying, MEM sees NOP bubbles; the real MUL word goes out with its product.
                r_dw <= 1'b0;
                if (w_mul_last) begin
                    r_mem_ir <= ex_ir;
                    r_reg_C  <= w_prod_next[WIDTH-1:0];
                    r_zf     <= (w_prod_next[WIDTH-1:0] == '0);
                    r_nf     <= w_prod_next[WIDTH-1];
                    r_cf     <= |w_prod_next[2*WIDTH-1:WIDTH];
                end else begin
                    r_mem_ir <= '0;
                end
            end else
`endif
            begin
                r_mem_ir <= ex_ir;
                r_reg_C  <= w_res;
                r_dw     <= (w_op == `STORE);
                if (w_flag_upd) begin
                    r_zf <= (w_res == '0);
                    r_nf <= w_res[WIDTH-1];
                    r_cf <= w_cf_new;
                end
            end
        end
    end

    assign mem_ir = r_mem_ir;
    assign reg_C  = r_reg_C;
    assign smdr1  = r_smdr1;
    assign dw     = r_dw;
    assign zf     = r_zf;
    assign nf     = r_nf;
    assign cf     = r_cf;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed literal checks plus randomized traffic against an arithmetic model.
// Outputs are compared every cycle 2 time units after the rising edge; inputs change on the falling edge.
// Reset is pulsed occasionally during random traffic; the model is cleared at the same instant.

`ifndef EX_STAGE_DEFINES
`define EX_STAGE_DEFINES
`define EXEC  1'b1
`define IDLE  1'b0
`define NOP   5'b00000
`define HALT  5'b00001
`define LOAD  5'b00010
`define STORE 5'b00011
`define SLL   5'b00100
`define SRL   5'b00101
`define SLA   5'b00110
`define SRA   5'b00111
`define ADD   5'b01000
`define ADDI  5'b01001
`define SUB   5'b01010
`define SUBI  5'b01011
`define CMP   5'b01100
`define AND   5'b01101
`define OR    5'b01110
`define XOR   5'b01111
`define LDIH  5'b10000
`define ADDC  5'b10001
`define SUBC  5'b10010
`define MUL   5'b10011
`define JUMP  5'b11000
`endif

module tb_ex_stage;
    localparam int MUL_CYC = 16;

    logic        clock = 1'b0;
    logic        reset, state;
    logic [15:0] ex_ir, reg_A, reg_B, smdr;
    logic [15:0] mem_ir, reg_C, smdr1;
    logic        dw, zf, nf, cf, stall;

    ex_stage dut (
        .clock(clock), .reset(reset), .state(state), .ex_ir(ex_ir),
        .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr),
        .mem_ir(mem_ir), .reg_C(reg_C), .dw(dw), .smdr1(smdr1),
        .zf(zf), .nf(nf), .cf(cf), .stall(stall)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model of the architectural outputs after the next rising edge.
    logic [15:0] m_mem_ir, m_reg_C, m_smdr1;
    logic        m_dw, m_zf, m_nf, m_cf;
    int          m_mul_edges;
    logic [15:0] m_mul_a, m_mul_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] irw(input logic [4:0] op);
        return {op, 11'h2A5};
    endfunction

    function automatic logic m_stall();
`ifdef EX_MUL_EN
        return (ex_ir[15:11] == `MUL) && (m_mul_edges != MUL_CYC);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mem_ir = 0; m_reg_C = 0; m_smdr1 = 0;
        m_dw = 0; m_zf = 0; m_nf = 0; m_cf = 0;
        m_mul_edges = 0;
    endtask

    task automatic model_update();
        int unsigned a, b, c, res, sh;
        logic [4:0] op;
        bit upd, ncf;
        int s;
        a = reg_A; b = reg_B; c = m_cf; sh = b % 16;
        op = ex_ir[15:11]; upd = 0; ncf = 0; res = 0;
        if (state != `EXEC) return;
        m_smdr1 = smdr;
`ifdef EX_MUL_EN
        if (m_mul_edges > 0 || op == `MUL) begin
            if (m_mul_edges == 0) begin m_mul_a = reg_A; m_mul_b = reg_B; end
            m_mul_edges++;
            m_dw = 0;
            if (m_mul_edges == MUL_CYC + 1) begin
                longint unsigned p;
                p = longint'(m_mul_a) * longint'(m_mul_b);
                m_reg_C = p[15:0];
                m_zf = (p % 65536) == 0;
                m_nf = p[15];
                m_cf = (p >> 16) != 0;
                m_mem_ir = ex_ir;
                m_mul_edges = 0;
            end else begin
                m_mem_ir = 0;
            end
            return;
        end
`endif
        m_mem_ir = ex_ir;
        m_dw = (op == `STORE);
        case (op)
            `ADD, `ADDI:       begin res = a + b;     ncf = res > 65535; upd = 1; end
            `LOAD, `STORE:     res = a + b;
            `ADDC:             begin res = a + b + c; ncf = res > 65535; upd = 1; end
            `SUB, `SUBI, `CMP: begin res = a - b;     ncf = a < b;       upd = 1; end
            `SUBC:             begin res = a - b - c; ncf = a < b + c;   upd = 1; end
            `AND:              begin res = a & b; upd = 1; end
            `OR:               begin res = a | b; upd = 1; end
            `XOR:              begin res = a ^ b; upd = 1; end
            `SLL, `SLA:        begin res = a << sh; upd = 1; end
            `SRL:              begin res = a >> sh; upd = 1; end
            `SRA: begin
                s = (a >= 32768) ? int'(a) - 65536 : int'(a);
                res = unsigned'(s >>> sh); upd = 1;
            end
            `LDIH:             res = b;
            default:           res = 0;
        endcase
        m_reg_C = res[15:0];
        if (upd) begin
            m_zf = (res % 65536) == 0;
            m_nf = res[15];
            m_cf = ncf;
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(posedge clock) begin
        #2;
        if (chk_en) begin
            chk("mem_ir", mem_ir, m_mem_ir);
            chk("reg_C",  reg_C,  m_reg_C);
            chk("smdr1",  smdr1,  m_smdr1);
            chk("dw",     dw,     m_dw);
            chk("zf",     zf,     m_zf);
            chk("nf",     nf,     m_nf);
            chk("cf",     cf,     m_cf);
            chk("stall",  stall,  m_stall());
        end
    end

    task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] s, input logic st);
        @(negedge clock);
        state = st; ex_ir = irw(op); reg_A = a; reg_B = b; smdr = s;
        if (reset) model_update();
        @(posedge clock); #3;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset = 0; state = `IDLE; ex_ir = 0; reg_A = 0; reg_B = 0; smdr = 0;
        model_reset();
        m_mul_a = 0; m_mul_b = 0;
        repeat (2) @(posedge clock);
        #3;
        chk("rst_mem_ir", mem_ir, 0);
        chk("rst_reg_C", reg_C, 0);
        chk("rst_flags", {zf, nf, cf, dw}, 0);
        chk_en = 1;
        @(negedge clock); reset = 1;

        // ADD overflow into the sign bit
        drive(`ADD, 16'h7FFF, 16'h0001, 16'h0000, `EXEC);
        chk("t1_reg_C", reg_C, 16'h8000);
        chk("t1_flags_znc", {zf, nf, cf}, 3'b010);
        chk("t1_mem_ir", mem_ir, irw(`ADD));

        // SUB equal, SUB borrow, ADDC consuming the borrow as carry-in
        drive(`SUB, 16'd5, 16'd5, 16'h0000, `EXEC);
        chk("t2_sub0_reg_C", reg_C, 0);
        chk("t2_sub0_flags", {zf, nf, cf}, 3'b100);
        drive(`SUB, 16'd3, 16'd5, 16'h0000, `EXEC);
        chk("t2_sub_borrow_reg_C", reg_C, 16'hFFFE);
        chk("t2_sub_borrow_flags", {zf, nf, cf}, 3'b011);
        drive(`ADDC, 16'd1, 16'd1, 16'h0000, `EXEC);
        chk("t2_addc_reg_C", reg_C, 16'd3);

        // STORE: address, write enable, data; flags untouched
        drive(`SUB, 16'd3, 16'd5, 16'h0000, `EXEC);
        drive(`STORE, 16'h0010, 16'h0004, 16'hBEEF, `EXEC);
        chk("t3_reg_C", reg_C, 16'h0014);
        chk("t3_dw", dw, 1);
        chk("t3_smdr1", smdr1, 16'hBEEF);
        chk("t3_flags_held", {zf, nf, cf}, 3'b011);
        drive(`NOP, 16'h1111, 16'h2222, 16'h0000, `EXEC);
        chk("t3_nop_dw", dw, 0);
        chk("t3_nop_reg_C", reg_C, 0);

        // Shifts
        drive(`SRA, 16'h8000, 16'd3, 16'h0000, `EXEC);
        chk("t4_sra_reg_C", reg_C, 16'hF000);
        chk("t4_sra_flags", {zf, nf, cf}, 3'b010);
        drive(`SRL, 16'h8000, 16'd3, 16'h1234, `EXEC);
        chk("t4_srl_reg_C", reg_C, 16'h1000);

        // Not exec: everything holds
        repeat (4) drive(`ADD, 16'd1, 16'd2, 16'h5555, `IDLE);
        chk("t5_hold_reg_C", reg_C, 16'h1000);
        chk("t5_hold_mem_ir", mem_ir, irw(`SRL));
        chk("t5_hold_smdr1", smdr1, 16'h1234);
        chk("t5_hold_flags", {zf, nf, cf}, 3'b000);

        // Asynchronous reset in the low phase of the clock
        @(negedge clock); #1;
        reset = 0; model_reset();
        #1;
        chk("t5_async_reg_C", reg_C, 0);
        chk("t5_async_mem_ir", mem_ir, 0);
        chk("t5_async_smdr1", smdr1, 0);
        @(negedge clock);
        state = `IDLE; ex_ir = 0; reset = 1;

`ifdef EX_MUL_EN
        begin
            int stall_cnt;
            bit retired, st;
            stall_cnt = 0; retired = 0;
            for (int k = 0; k < 40 && !retired; k++) begin
                @(negedge clock);
                state = `EXEC; ex_ir = irw(`MUL); reg_A = 16'd300; reg_B = 16'd300; smdr = 0;
                model_update();
                #1 st = stall;
                if (st) stall_cnt++;
                @(posedge clock); #3;
                if (st) chk("t6_bubble_mem_ir", mem_ir, 0);
                else retired = 1;
            end
            chk("t6_retired", retired, 1);
            chk("t6_stall_cycles", stall_cnt, 16);
            chk("t6_reg_C", reg_C, 16'h5F90);
            chk("t6_flags", {zf, nf, cf}, 3'b001);
            chk("t6_mem_ir", mem_ir, irw(`MUL));
            drive(`NOP, 0, 0, 0, `EXEC);
            // Abort after 8 iterations
            repeat (9) drive(`MUL, 16'd300, 16'd300, 16'h0000, `EXEC);
            @(negedge clock); #1;
            reset = 0; model_reset(); ex_ir = 0;
            #1;
            chk("t6_abort_reg_C", reg_C, 0);
            chk("t6_abort_mem_ir", mem_ir, 0);
            @(negedge clock); reset = 1; state = `IDLE;
            drive(`ADD, 16'd1, 16'd1, 16'h0000, `EXEC);
            chk("t6_after_abort_reg_C", reg_C, 16'd2);
            chk("t6_after_abort_mem_ir", mem_ir, irw(`ADD));
            chk("t6_after_abort_stall", stall, 0);
        end
`else
        drive(`SUB, 16'd3, 16'd5, 16'h0000, `EXEC);
        @(negedge clock);
        state = `EXEC; ex_ir = irw(`MUL); reg_A = 16'd300; reg_B = 16'd300; smdr = 0;
        model_update();
        #1 chk("t6_nomul_stall", stall, 0);
        @(posedge clock); #3;
        chk("t6_nomul_reg_C", reg_C, 0);
        chk("t6_nomul_flags_held", {zf, nf, cf}, 3'b011);
`endif

        // Randomized traffic; operands are held while the model expects a stall
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (!reset) reset = 1;
            if (!m_stall()) begin
                ex_ir = {5'($urandom_range(0, 31)), 11'($urandom)};
                reg_A = pick(); reg_B = pick(); smdr = 16'($urandom);
            end
            state = ($urandom_range(0, 9) != 0) ? `EXEC : `IDLE;
            if ($urandom_range(0, 299) == 0) begin
                reset = 0; model_reset();
            end else begin
                model_update();
            end
        end
        @(posedge clock); #3;
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
